reg_display_scanner: RTL and testbench

//  Initiator on the core's register-debug read port (dispSel/dispDat): selects a register,

---
 rtl/reg_display_scanner_pkg.sv | 20 ++
 rtl/reg_display_scanner_hex7seg.sv | 11 +
 rtl/reg_display_scanner.sv | 128 ++++++++++++
 tb/tb_reg_display_scanner.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_display_scanner_pkg.sv
// Shared definitions for the register display scanner: FSM encoding, digit count
// and the active-low 7-segment pattern table.
package reg_display_scanner_pkg;

  localparam int DIGITS = 8;

  typedef enum logic [1:0] {
    ST_SELECT  = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SCAN    = 2'd3
  } scan_state_t;

  // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/reg_display_scanner_hex7seg.sv
// Nibble to active-low 7-segment pattern; purely combinational, the caller registers it.
module reg_display_scanner_hex7seg
  import reg_display_scanner_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/reg_display_scanner.sv
// Reads one core register per frame through the debug port and multiplexes its
// eight hex digits onto a common-anode display, optionally stepping through $0..$31.
//
// state   | meaning
// SELECT  | drive register address (manual switches or auto-step register)
// SETTLE  | wait one cycle for the debug read to settle
// CAPTURE | latch register value, pulse frame, restart digit scan
// SCAN    | light digits 0..7 for REFRESH_DIV cycles each, then back to SELECT
module reg_display_scanner
  import reg_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int STEP_FRAMES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  sel_sw,
  input  logic        auto_en,
  output logic [4:0]  dispSel,
  input  logic [31:0] dispDat,
  output logic [4:0]  cur_reg,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        frame
);

  localparam int PW = $clog2(REFRESH_DIV) + 1;
  localparam int FW = $clog2(STEP_FRAMES) + 1;
  localparam logic [PW-1:0] PS_TC      = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FC_TC      = FW'(STEP_FRAMES - 1);
  localparam logic [2:0]    LAST_DIGIT = 3'(DIGITS - 1);

  scan_state_t   r_state;
  scan_state_t   w_next_state;
  logic [PW-1:0] r_prescale;
  logic [2:0]    r_digit;
  logic [FW-1:0] r_fcnt;
  logic [4:0]    r_step;
  logic [4:0]    r_sel;
  logic          r_auto;
  logic [31:0]   r_latch;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_frame;
  logic          w_tc;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;

  assign w_tc  = (r_prescale == PS_TC);
  assign w_nib = r_latch[4*r_digit +: 4];

  reg_display_scanner_hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_SELECT:  w_next_state = ST_SETTLE;
      ST_SETTLE:  w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_SCAN;
      ST_SCAN:    if (w_tc && (r_digit == LAST_DIGIT)) w_next_state = ST_SELECT;
      default:    w_next_state = ST_SELECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_SELECT;
      r_prescale <= '0;
      r_digit    <= '0;
      r_fcnt     <= '0;
      r_step     <= '0;
      r_sel      <= '0;
      r_auto     <= 1'b0;
      r_latch    <= '0;
      r_an       <= 8'hFF;
      r_seg      <= 7'h7F;
      r_frame    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_frame <= (r_state == ST_CAPTURE);
      // Blanked unless scanning, so nothing ghosts while the source changes
      r_an    <= 8'hFF;
      r_seg   <= 7'h7F;
      case (r_state)
        ST_SELECT: begin
          r_sel  <= auto_en ? r_step : sel_sw;
          r_auto <= auto_en;
        end
        ST_CAPTURE: begin
          r_latch    <= dispDat;
          r_digit    <= '0;
          r_prescale <= '0;
          if (r_auto) begin
            if (r_fcnt == FC_TC) begin
              r_fcnt <= '0;
              r_step <= r_step + 5'd1;
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end else begin
            r_fcnt <= '0;
          end
        end
        ST_SCAN: begin
          r_an  <= ~(8'b1 << r_digit);
          r_seg <= w_seg;
          if (w_tc) begin
            r_prescale <= '0;
            r_digit    <= r_digit + 3'd1;
          end else begin
            r_prescale <= r_prescale + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dispSel = r_sel;
  assign cur_reg = r_sel;
  assign an      = r_an;
  assign seg     = r_seg;
  assign frame   = r_frame;

endmodule

// File: tb/tb_reg_display_scanner.sv
// Directed bench: REFRESH_DIV=4 / STEP_FRAMES=2 main instance plus a REFRESH_DIV=1 instance,
// both reading a register-file model through the debug port.
module tb_reg_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  sel_sw = 5'd0;
  logic        auto_en = 1'b0;
  logic [31:0] regs [32];

  logic [4:0]  sel0, cur0, sel1, cur1;
  logic [31:0] dat0, dat1;
  logic [6:0]  seg0, seg1;
  logic [7:0]  an0, an1;
  logic        frame0, frame1;

  logic [6:0]  seg_tab [16];
  logic [7:0]  an_tab [8];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign dat0 = regs[sel0];
  assign dat1 = regs[sel1];

  reg_display_scanner #(.REFRESH_DIV(4), .STEP_FRAMES(2)) dut (
    .clk(clk), .reset(rst), .sel_sw(sel_sw), .auto_en(auto_en),
    .dispSel(sel0), .dispDat(dat0), .cur_reg(cur0),
    .seg(seg0), .an(an0), .frame(frame0)
  );

  reg_display_scanner #(.REFRESH_DIV(1), .STEP_FRAMES(2)) dut_fast (
    .clk(clk), .reset(rst), .sel_sw(sel_sw), .auto_en(auto_en),
    .dispSel(sel1), .dispDat(dat1), .cur_reg(cur1),
    .seg(seg1), .an(an1), .frame(frame1)
  );

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame0 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++;
    if (!seen) $display("FAIL wait_frame: frame got none in 100 cycles, expected a pulse");
    else n_pass++;
  endtask

  // Entered at the negedge where frame is high; leaves at the next frame's pulse.
  task automatic check_frame(input logic [31:0] val, input logic [4:0] reg_no,
                             input bit do_wr, input logic [31:0] wr_val);
    logic [3:0] nib;
    n_total++;
    if (cur0 !== reg_no || sel0 !== reg_no)
      $display("FAIL frame_reg: cur_reg %0d dispSel %0d, expected %0d", cur0, sel0, reg_no);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (do_wr && i == 10) regs[reg_no] = wr_val;
      nib = val[4*(i/4) +: 4];
      n_total++;
      if (an0 !== an_tab[i/4] || seg0 !== seg_tab[nib])
        $display("FAIL scan[%0d]: an=%h seg=%h, expected an=%h seg=%h",
                 i, an0, seg0, an_tab[i/4], seg_tab[nib]);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (i < 2) begin
        if (an0 !== 8'hFF || frame0 !== 1'b0)
          $display("FAIL blank[%0d]: an=%h frame=%b, expected an=ff frame=0", i, an0, frame0);
        else n_pass++;
      end else begin
        if (frame0 !== 1'b1)
          $display("FAIL period: frame=%b at cycle 35, expected 1", frame0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel_sw = 5'd5;
    auto_en = 1'b0;
    regs[5] = 32'h1234ABCD;
    repeat (3) @(negedge clk);
    n_total++;
    if (an0 !== 8'hFF || seg0 !== 7'h7F || sel0 !== 5'd0 || frame0 !== 1'b0 || cur0 !== 5'd0)
      $display("FAIL reset_state: an=%h seg=%h dispSel=%0d frame=%b cur=%0d, expected ff 7f 0 0 0",
               an0, seg0, sel0, frame0, cur0);
    else n_pass++;
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_total++;
      if (frame0 !== (i == 3))
        $display("FAIL reset_frame[%0d]: frame=%b, expected %b", i, frame0, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_manual();
    check_frame(32'h1234ABCD, 5'd5, 1'b0, 32'h0);
  endtask

  task automatic test_coherence();
    check_frame(32'h1234ABCD, 5'd5, 1'b1, 32'hFFFF0000);
    check_frame(32'hFFFF0000, 5'd5, 1'b0, 32'h0);
  endtask

  task automatic test_auto_step();
    logic [4:0] exp_reg;
    rst = 1'b1;
    auto_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // 0,0,1,1,...,30,30,31,31,0 then one manual frame, then 0,0,1
    for (int k = 0; k < 69; k++) begin
      wait_frame();
      if (k < 65)       exp_reg = 5'((k / 2) % 32);
      else if (k == 65) exp_reg = 5'd5;
      else if (k == 66) exp_reg = 5'd0;
      else if (k == 67) exp_reg = 5'd0;
      else              exp_reg = 5'd1;
      if (k >= 58) begin
        n_total++;
        if (cur0 !== exp_reg || sel0 !== exp_reg)
          $display("FAIL auto_frame[%0d]: cur_reg %0d dispSel %0d, expected %0d", k, cur0, sel0, exp_reg);
        else n_pass++;
      end
      if (k == 64) auto_en = 1'b0;
      if (k == 65) auto_en = 1'b1;
    end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    wait_frame();
    wait_frame();
    repeat (14) @(negedge clk);
    n_total++;
    if (an0 !== 8'hF7)
      $display("FAIL pre_reset_digit: an=%h, expected f7", an0);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (an0 !== 8'hFF || seg0 !== 7'h7F || sel0 !== 5'd0 || frame0 !== 1'b0)
      $display("FAIL mid_reset: an=%h seg=%h dispSel=%0d frame=%b, expected ff 7f 0 0",
               an0, seg0, sel0, frame0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (sel0 !== 5'd0 || an0 !== 8'hFF)
      $display("FAIL post_release: dispSel=%0d an=%h, expected 0 ff", sel0, an0);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (frame0 !== 1'b1 || cur0 !== 5'd5)
      $display("FAIL restart_frame: frame=%b cur_reg=%0d, expected 1 5", frame0, cur0);
    else n_pass++;
  endtask

  task automatic test_refresh_div1();
    bit seen;
    logic [6:0] exp_seg;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frame1 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++;
    if (!seen) $display("FAIL fast_sync: frame got none in 50 cycles, expected a pulse");
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      n_total++;
      if (i < 8) begin
        exp_seg = (i < 4) ? 7'h40 : 7'h0E;
        if (an1 !== an_tab[i] || seg1 !== exp_seg || frame1 !== 1'b0)
          $display("FAIL fast_scan[%0d]: an=%h seg=%h frame=%b, expected an=%h seg=%h frame=0",
                   i, an1, seg1, frame1, an_tab[i], exp_seg);
        else n_pass++;
      end else if (i < 10) begin
        if (an1 !== 8'hFF || frame1 !== 1'b0)
          $display("FAIL fast_blank[%0d]: an=%h frame=%b, expected ff 0", i, an1, frame1);
        else n_pass++;
      end else begin
        if (frame1 !== 1'b1)
          $display("FAIL fast_period: frame=%b at cycle 11, expected 1", frame1);
        else n_pass++;
      end
    end
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    for (int r = 0; r < 32; r++) regs[r] = 32'h0101_0101 * r;

    test_reset();
    test_manual();
    test_coherence();
    test_auto_step();
    test_reset_mid_scan();
    test_refresh_div1();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
